// File: rtl/rgb_to_gray.sv
// RGB-to-grayscale front end: pops packed RGB pixels, emits 8-bit gray through a two-stage
// pipeline and pulses done once per frame. Define GRAY_WEIGHTED_EN for luma weights instead of an average.

module rgb_to_gray #(
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 720
) (
    input  logic        clock,
    input  logic        reset,
    output logic        rgb_rd_en,
    input  logic        rgb_empty,
    input  logic [23:0] rgb_dout,
    output logic        gray_wr_en,
    input  logic        gray_full,
    output logic [7:0]  gray_din,
    output logic        done
);

    localparam logic [31:0] PIXELS = 32'(IMG_WIDTH * IMG_HEIGHT);

`ifdef GRAY_WEIGHTED_EN
    localparam int S1_W = 16;
`else
    localparam int S1_W = 10;
`endif

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e          state_q;
    logic [31:0]     in_cnt_q;
    logic [31:0]     out_cnt_q;
    logic            s1_valid_q;
    logic            s2_valid_q;
    logic            done_q;
    logic [S1_W-1:0] s1_q;
    logic [7:0]      s2_q;

    logic [S1_W-1:0] s1_d;
    logic [7:0]      s2_d;
    logic            advance;
    logic [7:0]      red;
    logic [7:0]      green;
    logic [7:0]      blue;

    assign red   = rgb_dout[23:16];
    assign green = rgb_dout[15:8];
    assign blue  = rgb_dout[7:0];

`ifdef GRAY_WEIGHTED_EN
    // Weights sum to 256, so the shifted result never exceeds 255.
    assign s1_d = 16'(red) * 16'd77 + 16'(green) * 16'd150 + 16'(blue) * 16'd29;
    assign s2_d = 8'(s1_q >> 8);
`else
    // 683/2048 reproduces floor(sum/3) exactly over the whole 0..765 range.
    assign s1_d = 10'(red) + 10'(green) + 10'(blue);
    assign s2_d = 8'((20'(s1_q) * 20'd683) >> 11);
`endif

    // The whole pipeline moves only when the output stage can drain or is empty.
    assign advance    = !s2_valid_q || !gray_full;
    assign rgb_rd_en  = !reset && (state_q == RUN) && !rgb_empty && advance && (in_cnt_q < PIXELS);
    assign gray_wr_en = s2_valid_q && !gray_full;
    assign gray_din   = s2_valid_q ? s2_q : 8'd0;
    assign done       = done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: data registers are reset too so gray_din can never expose stale pixels.
            state_q    <= RUN;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            done_q     <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments let later statements override earlier ones (DONE clears below).
            done_q <= 1'b0;
            if (advance) begin
                s2_q       <= s2_d;
                s2_valid_q <= s1_valid_q;
                s1_valid_q <= rgb_rd_en;
            end
            if (rgb_rd_en) begin
                s1_q     <= s1_d;
                in_cnt_q <= in_cnt_q + 32'd1;
            end
            if (gray_wr_en) begin
                out_cnt_q <= out_cnt_q + 32'd1;
            end
            case (state_q)
                RUN: begin
                    if (rgb_rd_en && (in_cnt_q == PIXELS - 32'd1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (gray_wr_en && (out_cnt_q == PIXELS - 32'd1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= RUN;
                    in_cnt_q   <= '0;
                    out_cnt_q  <= '0;
                    s1_valid_q <= 1'b0;
                    s2_valid_q <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: doc/rgb_to_gray.md
Name: rgb_to_gray

Overview:
- Front-end producer for the edge-detection pipeline.
- Pops packed 24-bit RGB pixels from an upstream show-ahead FIFO and converts each to an 8-bit grayscale value.
- Pushes results into the gray FIFO that the Sobel stage drains.
- Counts pixels per frame and pulses done once the final gray pixel of the frame is written.

Parameters:
IMG_WIDTH, 540, pixels per row
IMG_HEIGHT, 720, rows per frame
PIXELS, IMG_WIDTH*IMG_HEIGHT, pixels per frame (derived; not overridden independently)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
rgb_rd_en  output  1  pop strobe to RGB FIFO
rgb_empty  input  1  RGB FIFO empty
rgb_dout  input  24  show-ahead head word; [23:16]=R, [15:8]=G, [7:0]=B; valid whenever rgb_empty=0
gray_wr_en  output  1  push strobe to gray FIFO
gray_full  input  1  gray FIFO full
gray_din  output  8  gray pixel, valid when gray_wr_en=1
done  output  1  one-cycle pulse after last pixel of frame is written

Behaviour:
- Reset: clock is clock; reset is reset, asynchronous, active-high. All state is cleared asynchronously:
  - state=RUN, in_cnt=0, out_cnt=0, s1_valid=0, s2_valid=0, done=0.
  - rgb_rd_en, gray_wr_en and gray_din read 0 while reset is high.
- Pipeline: two register stages, s1 and s2, each with a valid bit.
  - advance = !s2_valid || !gray_full.
  - s1 holds sum = R+G+B (10-bit, unsigned, max 765).
  - s2 holds gray = (sum*683)>>11. This equals floor(sum/3) exactly for sum<=765; the product is 20-bit.
- Pop (combinational): rgb_rd_en = (state==RUN) && !rgb_empty && advance && (in_cnt<PIXELS).
  - On a pop, rgb_dout is captured into s1 at the same edge.
- Write (combinational): gray_wr_en = s2_valid && !gray_full; gray_din = s2 value, and 0 when s2_valid=0.
- Stage update on each edge when advance=1:
  - s2 <= s1 and s2_valid <= s1_valid.
  - s1_valid <= rgb_rd_en.
- Stall: when advance=0, both stages hold and no pop occurs. No pixel is ever dropped or duplicated under arbitrary gray_full/rgb_empty toggling.
- Latency: a word popped in cycle N appears with gray_wr_en in cycle N+2 if gray_full stays 0. Sustained throughput is 1 pixel/cycle.
- Counters:
  - in_cnt increments on each pop and saturates at PIXELS.
  - out_cnt increments on each write.
  - Both are 32-bit unsigned.
- States:
  - RUN: pops allowed. Go to DRAIN when in_cnt reaches PIXELS, i.e. on the edge of the final pop.
  - DRAIN: no pops; pipeline continues writing. Go to DONE on the edge where out_cnt becomes PIXELS.
  - DONE: done=1 (registered) for exactly this one cycle. Counters and valids clear, and the next edge returns to RUN for the next frame. No pop or write happens in DONE.
- Boundaries:
  - Pop and write in the same cycle are legal and independent.
  - gray_full asserted with s2 full stalls the whole pipeline, including pops.
  - rgb_empty mid-frame inserts a bubble: s1_valid=0 propagates, and bubbles are not written.
  - Words beyond PIXELS in the RGB FIFO stay unpopped until the next frame starts.
  - Reset mid-frame aborts the frame immediately; partial pixels are discarded.

Optional Feature:
- Macro: GRAY_WEIGHTED_EN
- Defined: s1 holds weighted = 77*R + 150*G + 29*B (16-bit). s2 holds weighted>>8, which is max 255, so no saturation is needed.
- Undefined: plain average floor((R+G+B)/3) as above. Latency, handshake and counters are identical in both modes.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, PIXELS=8):
- Reset mid-frame: reset pulsed after 3 pops → all outputs 0 immediately. A following 8-pixel frame is processed correctly with out_cnt restarting at 0.
- Averaging, continuous stream:
  - Input RGB 0xFFFFFF, 0x000000, 0x030201, 0xFE0000 and 4×0x808080, FIFOs never empty/full.
  - Required gray_din: 255, 0, 2, 84, 128, 128, 128, 128.
  - First write 2 cycles after first pop; done pulses exactly one cycle, one cycle after the 8th write.
- Backpressure: gray_full held 1 for 5 cycles starting at the 3rd write → gray_wr_en=0 and rgb_rd_en=0 during the hold. Afterwards the output sequence continues with no loss or duplication; 8 total writes.
- Starvation: rgb_empty toggles 1/0 every cycle → one pop every 2 cycles. Outputs are in order with no writes for bubbles; done is still asserted once.
- Back-to-back frames: 16 words queued → two done pulses. No pop during the DONE cycle; the second frame's first pop occurs the cycle after DONE.
- GRAY_WEIGHTED_EN defined: input 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF → gray_din 76, 149, 28, 255.
